exc_ctrl: RTL and testbench

- Exception/interrupt initiator for the 5-stage MIPS pipeline. It produces the one-cycle illop/xadr pulses, the return address and the redirect vector consumed by the EX/MEM register and the PC mux.
- It samples ID-stage status each cycle and decides when a trap may be taken. It squashes younger stages and holds off further traps until kernel code reaches ID.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/exc_drain_cnt.sv | 19 +
 rtl/exc_ctrl.sv | 90 +++++++++
 tb/tb_exc_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared exception-controller types, trap vectors, register ids and cause codes
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, PEND, FIRE, DRAIN} exc_state_t;
  localparam logic [31:0] ILLOP_VEC_DEF = 32'h80000004;
  localparam logic [31:0] XADR_VEC_DEF  = 32'h80000008;
  localparam logic [4:0]  K0_REG        = 5'd26;
  localparam logic [1:0]  CAUSE_NONE    = 2'b00;
  localparam logic [1:0]  CAUSE_ILLOP   = 2'b01;
  localparam logic [1:0]  CAUSE_XADR    = 2'b10;
endpackage

// File: rtl/exc_drain_cnt.sv
// exc_drain_cnt: loadable down-counter whose zero flag marks the decrement that empties it
module exc_drain_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  // load wins over decrement; the count never wraps below zero
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt <= W'(1);
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: trap initiator (illop/xadr pulses, EPC, redirect vector, flushes); EXC_CAUSE_EN adds cause/count outputs
module exc_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] ILLOP_VEC    = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC     = XADR_VEC_DEF,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_req,
  input  logic        id_valid,
  input  logic        id_illegal,
  input  logic [31:0] id_pc,
  input  logic        stall,
  input  logic        ex_is_ctrl,
  output logic        illop,
  output logic        xadr,
  output logic [31:0] exc_epc,
  output logic [31:0] exc_target,
  output logic        flush_if,
  output logic        flush_id
`ifdef EXC_CAUSE_EN
  , output logic [1:0] exc_cause
  , output logic [7:0] exc_count
`endif
);
  exc_state_t state, state_nx;
  logic acc_ill, acc_irq, go_fire, drain_zero;
  logic illop_nx, xadr_nx, flush_nx;
  logic [31:0] epc_nx, tgt_nx;
  assign acc_ill = id_valid & id_illegal & ~stall & ~id_pc[31];
  assign acc_irq = irq_req & id_valid & ~stall & ~ex_is_ctrl & ~id_pc[31] & ~id_illegal;
  assign go_fire = (state == IDLE || state == PEND) && (acc_ill || acc_irq);
  exc_drain_cnt #(.W(3)) u_drain (
    .clk      (clk),
    .reset    (reset),
    .load     (state == FIRE),
    .dec      (state == DRAIN),
    .load_val (3'(DRAIN_CYCLES)),
    .zero     (drain_zero)
  );
  // state and registered trap outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      illop      <= 1'b0;
      xadr       <= 1'b0;
      exc_epc    <= '0;
      exc_target <= '0;
      flush_if   <= 1'b0;
      flush_id   <= 1'b0;
    end else begin
      state      <= state_nx;
      illop      <= illop_nx;
      xadr       <= xadr_nx;
      exc_epc    <= epc_nx;
      exc_target <= tgt_nx;
      flush_if   <= flush_nx;
      flush_id   <= flush_nx;
    end
  // next state: IDLE and PEND share the accept tests; PEND only tracks a waiting irq
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, PEND: state_nx = go_fire ? FIRE : irq_req ? PEND : IDLE;
      FIRE:       state_nx = DRAIN;
      DRAIN:      state_nx = drain_zero ? IDLE : DRAIN;
    endcase
  end
  // next outputs: illegal trap beats interrupt; interrupt EPC points at the victim so it re-executes
  always_comb begin
    illop_nx = go_fire & acc_ill;
    xadr_nx  = go_fire & ~acc_ill;
    flush_nx = go_fire;
    epc_nx   = go_fire ? (acc_ill ? id_pc + 32'd4 : id_pc) : exc_epc;
    tgt_nx   = go_fire ? (acc_ill ? ILLOP_VEC : XADR_VEC) : exc_target;
  end
`ifdef EXC_CAUSE_EN
  // cause latches with each trap; count saturates at 255
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      exc_cause <= CAUSE_NONE;
      exc_count <= '0;
    end else if (go_fire) begin
      exc_cause <= acc_ill ? CAUSE_ILLOP : CAUSE_XADR;
      exc_count <= exc_count == 8'hff ? exc_count : exc_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed and randomized checks of exc_ctrl against a cycle-counting trap model
module tb_exc_ctrl;
  localparam int DC = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic irq_req = 0, id_valid = 0, id_illegal = 0, stall = 0, ex_is_ctrl = 0;
  logic [31:0] id_pc = '0;
  logic illop, xadr, flush_if, flush_id;
  logic [31:0] exc_epc, exc_target;
`ifdef EXC_CAUSE_EN
  logic [1:0] exc_cause;
  logic [7:0] exc_count;
`endif
  int checks = 0, errors = 0;
  int quiet = 0, m_count = 0;
  logic m_ill = 0, m_x = 0;
  logic [31:0] m_epc = '0, m_tgt = '0;
  logic [1:0] m_cause = '0;

  exc_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .id_valid(id_valid),
    .id_illegal(id_illegal), .id_pc(id_pc), .stall(stall), .ex_is_ctrl(ex_is_ctrl),
    .illop(illop), .xadr(xadr), .exc_epc(exc_epc), .exc_target(exc_target),
    .flush_if(flush_if), .flush_id(flush_id)
`ifdef EXC_CAUSE_EN
    , .exc_cause(exc_cause), .exc_count(exc_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    quiet = 0; m_ill = 0; m_x = 0; m_epc = '0; m_tgt = '0; m_cause = '0; m_count = 0;
  endtask

  // a trap blocks the FIRE cycle plus DC drain cycles; otherwise any accepted instr traps
  task automatic model_step();
    logic ai, aq;
    ai = id_valid & id_illegal & ~stall & ~id_pc[31];
    aq = irq_req & id_valid & ~stall & ~ex_is_ctrl & ~id_pc[31] & ~id_illegal;
    m_ill = 0; m_x = 0;
    if (quiet > 0) quiet--;
    else if (ai || aq) begin
      m_ill = ai; m_x = !ai;
      m_epc = ai ? id_pc + 32'd4 : id_pc;
      m_tgt = ai ? 32'h80000004 : 32'h80000008;
      m_cause = ai ? 2'b01 : 2'b10;
      m_count = m_count < 255 ? m_count + 1 : 255;
      quiet = 1 + DC;
    end
  endtask

  task automatic compare();
    check("illop", {31'b0, illop}, {31'b0, m_ill});
    check("xadr", {31'b0, xadr}, {31'b0, m_x});
    check("flush_if", {31'b0, flush_if}, {31'b0, m_ill | m_x});
    check("flush_id", {31'b0, flush_id}, {31'b0, m_ill | m_x});
    check("exc_epc", exc_epc, m_epc);
    check("exc_target", exc_target, m_tgt);
`ifdef EXC_CAUSE_EN
    check("exc_cause", {30'b0, exc_cause}, {30'b0, m_cause});
    check("exc_count", {24'b0, exc_count}, m_count);
`endif
  endtask

  task automatic drive(input logic irq, input logic v, input logic ill, input logic st,
                       input logic ctrl, input logic [31:0] pc);
    irq_req = irq; id_valid = v; id_illegal = ill; stall = st; ex_is_ctrl = ctrl; id_pc = pc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 32'h00400100 + 32'(4 * i));
  endtask

  initial begin
    int xat;
    logic irq_lvl;
    repeat (3) @(negedge clk);
    model_reset();
    compare();
    check("rst_illop", {31'b0, illop}, 32'd0);
    reset = 0;
    idle(20);
    drive(0, 1, 1, 0, 0, 32'h00400010);
    check("t2_illop", {31'b0, illop}, 32'd1);
    check("t2_epc", exc_epc, 32'h00400014);
    check("t2_tgt", exc_target, 32'h80000004);
`ifdef EXC_CAUSE_EN
    check("t6_cause", {30'b0, exc_cause}, 32'd1);
`endif
    idle(5);
    repeat (3) drive(1, 1, 0, 0, 1, 32'h00400020);
    check("t3_noxadr", {31'b0, xadr}, 32'd0);
    drive(1, 1, 0, 0, 0, 32'h00400020);
    check("t3_xadr", {31'b0, xadr}, 32'd1);
    check("t3_epc", exc_epc, 32'h00400020);
    check("t3_tgt", exc_target, 32'h80000008);
    drive(0, 1, 0, 0, 0, 32'h00400024);
    idle(4);
    repeat (5) drive(1, 1, 0, 0, 0, 32'h80000100);
    check("t4_kernel_noxadr", {31'b0, xadr}, 32'd0);
    drive(1, 1, 0, 0, 0, 32'h00400040);
    check("t4_user_xadr", {31'b0, xadr}, 32'd1);
    drive(0, 1, 0, 0, 0, 32'h00400044);
    idle(4);
    drive(1, 1, 0, 0, 0, 32'h80000200);
    repeat (3) drive(0, 1, 0, 0, 0, 32'h80000204);
    idle(3);
    check("t4_pulse_notrap", {31'b0, xadr}, 32'd0);
    drive(1, 1, 1, 0, 0, 32'h00400050);
    check("t5_illop", {31'b0, illop}, 32'd1);
    check("t5_noxadr", {31'b0, xadr}, 32'd0);
    xat = -1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0, 0, 32'h00400060);
      if (xadr && xat < 0) xat = i;
    end
    check("t5_xadr_after_drain", xat, 3);
    idle(5);
    drive(0, 1, 1, 0, 0, 32'h00400070);
    check("t6_fire", {31'b0, illop}, 32'd1);
    #1 reset = 1;
    #1;
    model_reset();
    check("t6_rst_illop", {31'b0, illop}, 32'd0);
    check("t6_rst_flush", {30'b0, flush_if, flush_id}, 32'd0);
    check("t6_rst_epc", exc_epc, 32'd0);
    @(negedge clk);
    reset = 0;
    idle(4);
`ifdef EXC_CAUSE_EN
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 1, 0, 0, 32'h00401000 + 32'(4 * i));
      idle(3);
    end
    check("t6_count_sat", {24'b0, exc_count}, 32'd255);
`endif
    irq_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) irq_lvl = ~irq_lvl;
      drive(irq_lvl, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            {$urandom_range(0, 3) == 0, 3'b0, 26'($urandom), 2'b0});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
